// File: rtl/collision_lives_tracker_pkg.sv
// Shared game definitions: screen limits, coordinate width, FSM state codes
// and the bounding-box struct used by every sprite-pair comparator.
package collision_lives_tracker_pkg;

    localparam int COORD_W = 10;
    localparam int MAX_X   = 639;
    localparam int MAX_Y   = 479;

    // Game FSM encoding, kept as plain constants so older blocks can share it
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PLAY      = 2'd1;
    localparam logic [1:0] ST_HIT       = 2'd2;
    localparam logic [1:0] ST_GAME_OVER = 2'd3;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;  // left edge
        coord_t y;  // top edge
        coord_t w;  // width
        coord_t h;  // height
    } box_t;

endpackage

// File: rtl/collision_lives_tracker_box_overlap.sv
// Combinational axis-aligned box overlap test. Edges are summed one bit wider
// than the coordinates so right/bottom edges never wrap. Touching edges do not
// count as overlap (strict compares).
module box_overlap
    import collision_lives_tracker_pkg::*;
(
    input  box_t box_a,
    input  box_t box_b,
    output logic overlap
);

    logic [COORD_W:0] a_right, a_bottom, b_right, b_bottom;

    // Far edges in 11 bits, then the four strict separating-axis compares
    always_comb begin
        a_right  = {1'b0, box_a.x} + {1'b0, box_a.w};
        a_bottom = {1'b0, box_a.y} + {1'b0, box_a.h};
        b_right  = {1'b0, box_b.x} + {1'b0, box_b.w};
        b_bottom = {1'b0, box_b.y} + {1'b0, box_b.h};
        overlap  = ({1'b0, box_b.x} < a_right)  &&
                   ({1'b0, box_a.x} < b_right)  &&
                   ({1'b0, box_b.y} < a_bottom) &&
                   ({1'b0, box_a.y} < b_bottom);
    end

endmodule

// File: rtl/collision_lives_tracker.sv
// Player/obstacle collision detector plus lives and dodge-score keeping.
// Drives the collision level back to the obstacle mover and the status bits
// consumed by the renderer.
module collision_lives_tracker
    import collision_lives_tracker_pkg::*;
#(
    parameter logic [3:0] LIVES_INIT = 4'd3,
    parameter int         SCORE_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic               start,
    input  logic [9:0]         player_x_pos,
    input  logic [9:0]         player_y_pos,
    input  logic [9:0]         player_width,
    input  logic [9:0]         player_height,
    input  logic [9:0]         obstacle_x_pos,
    input  logic [9:0]         obstacle_y_pos,
    input  logic [9:0]         obstacle_width,
    input  logic [9:0]         obstacle_height,
    output logic               collision,
    output logic [3:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               play_active,
    output logic               game_over
);

    box_t       player_box, obstacle_box;
    logic       overlap, overlap_q;
    logic [1:0] state;
    coord_t     prev_y;
    logic       hit_tick;   // suppresses the score for the respawn wrap after a hit
    logic       rearm;      // overlap must clear once before the next hit counts
    logic       take_hit;
    logic       wrapped;

    assign player_box   = '{x: player_x_pos,   y: player_y_pos,
                            w: player_width,   h: player_height};
    assign obstacle_box = '{x: obstacle_x_pos, y: obstacle_y_pos,
                            w: obstacle_width, h: obstacle_height};

    box_overlap u_overlap (
        .box_a   (player_box),
        .box_b   (obstacle_box),
        .overlap (overlap)
    );

    assign take_hit    = (state == ST_PLAY) && overlap_q && rearm;
    assign wrapped     = obstacle_y_pos < prev_y;
    assign play_active = (state == ST_PLAY) || (state == ST_HIT);
    assign game_over   = (state == ST_GAME_OVER);

    // Register the overlap so the FSM sees a clean one-clock-late level
    always_ff @(posedge clk) begin
        if (rst) overlap_q <= 1'b0;
        else     overlap_q <= overlap;
    end

    // Game FSM with lives/score counters and the collision handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            collision <= 1'b0;
            lives     <= 4'd0;
            score     <= '0;
            prev_y    <= '0;
            hit_tick  <= 1'b0;
            rearm     <= 1'b1;
        end else begin
            // Wrap detection history and hit_tick expiry run in every state;
            // the HIT exit below overrides hit_tick when both happen.
            if (game_en) begin
                prev_y   <= obstacle_y_pos;
                hit_tick <= 1'b0;
            end
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        state <= ST_PLAY;
                        lives <= LIVES_INIT;
                        score <= '0;
                        rearm <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (take_hit) begin
                        state     <= ST_HIT;
                        collision <= 1'b1;
                        lives     <= lives - 4'd1;
                        rearm     <= 1'b0;
                    end else begin
                        if (!overlap_q) rearm <= 1'b1;
                        if (game_en && wrapped && !hit_tick && !(&score))
                            score <= score + 1'b1;
                    end
                end
                ST_HIT: begin
                    // The mover samples collision on this tick; release after it
                    if (game_en) begin
                        collision <= 1'b0;
                        hit_tick  <= 1'b1;
                        state     <= (lives == 4'd0) ? ST_GAME_OVER : ST_PLAY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
